shift_right_unit: RTL and testbench

Multi-cycle right shifter for the ALU, the counterpart of the combinational left-shift gate. It performs logical or arithmetic right shifts one bit position per clock cycle, which trades latency for area. It accepts an operand and shift amount on a start pulse and reports the result with a one-cycle done strobe. It sits beside the ALU's combinational datapath and is sequenced by the control unit through `start_i`/`busy_o`/`done_o`.

---
 rtl/alu_pkg.sv | 15 +
 rtl/shift_right_step.sv | 22 ++
 rtl/shift_right_unit.sv | 121 ++++++++++++
 tb/tb_shift_right_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: right-shifter state encoding and counter sizing.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shr_state_t;

   // Counter must be able to hold the clamped amount WIDTH itself.
   function automatic int shr_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_right_step.sv
// One-bit right shift of a WIDTH bus; fill is the MSB when arith, else zero.
module shift_right_step #(
   parameter int WIDTH = 32
) (
   input  logic             arith,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out
);

   logic fill_s;

   // Select the bit shifted into the MSB position.
   always_comb begin
      if (arith) begin
         fill_s = bus_in[WIDTH-1];
      end else begin
         fill_s = 1'b0;
      end
      bus_out = {fill_s, bus_in[WIDTH-1:1]};
   end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle logical/arithmetic right shifter, one bit position per clock.
// Sequenced by start_i / busy_o / done_o; bus_o is the data register itself.
module shift_right_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             arith_i,
   input  logic [WIDTH-1:0] bus_i,
   input  logic [WIDTH-1:0] shift_i,
   output logic [WIDTH-1:0] bus_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int               CW        = shr_cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_AMT = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    CNT_MAX   = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);

   shr_state_t       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             arith_q, arith_d;
   logic [CW-1:0]    amt_s;
   logic [WIDTH-1:0] step_s;

   shift_right_step #(.WIDTH(WIDTH)) u_step (
      .arith   (arith_q),
      .bus_in  (data_q),
      .bus_out (step_s)
   );

   // Clamp the requested amount to WIDTH; anything larger fully drains the operand.
   always_comb begin
      if (shift_i >= WIDTH_AMT) begin
         amt_s = CNT_MAX;
      end else begin
         amt_s = shift_i[CW-1:0];
      end
   end

   // State, data, counter and latched mode registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= CNT_ZERO;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (amt_s == CNT_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on accepted start, shift and count down while in SHIFT.
   always_comb begin
      data_d  = data_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               data_d  = bus_i;
               cnt_d   = amt_s;
               arith_d = arith_i;
            end else begin
               data_d  = data_q;
            end
         end
         SHIFT: begin
            data_d = step_s;
            cnt_d  = cnt_q - CNT_ONE;
         end
         default: begin
            data_d = data_q;
         end
      endcase
   end

   // Outputs decoded from state; the result is the data register.
   always_comb begin
      bus_o  = data_q;
      busy_o = (state_q != IDLE);
      done_o = (state_q == DONE);
   end

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed self-checking bench for shift_right_unit at WIDTH=8.
module tb_shift_right_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic         arith_i;
   logic [W-1:0] bus_i;
   logic [W-1:0] shift_i;
   logic [W-1:0] bus_o;
   logic         busy_o;
   logic         done_o;

   int checks   = 0;
   int failures = 0;

   shift_right_unit #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .arith_i (arith_i),
      .bus_i   (bus_i),
      .shift_i (shift_i),
      .bus_o   (bus_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a request in the current (IDLE) cycle and follow it to completion.
   task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] s,
                         input logic a, input int n, input logic [W-1:0] exp);
      bus_i = b; shift_i = s; arith_i = a; start_i = 1'b1;
      for (int c = 1; c <= n + 1; c++) begin
         step();
         start_i = 1'b0;
         check({tag, "_busy"}, W'(busy_o), W'(1'b1));
         check({tag, "_done"}, W'(done_o), W'(c == n + 1));
      end
      check({tag, "_result"}, bus_o, exp);
      step();
      check({tag, "_idle_busy"}, W'(busy_o), W'(1'b0));
      check({tag, "_idle_done"}, W'(done_o), W'(1'b0));
      check({tag, "_hold"}, bus_o, exp);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; arith_i = 1'b0; bus_i = '0; shift_i = '0;
      step(); step();
      check("rst_bus", bus_o, 8'h00);
      check("rst_busy", W'(busy_o), W'(1'b0));
      check("rst_done", W'(done_o), W'(1'b0));
      rst_i = 1'b0;
      step();

      run_op("t1_lsr3", 8'hB4, 8'd3, 1'b0, 3, 8'h16);
      run_op("t2_asr3", 8'hB4, 8'd3, 1'b1, 3, 8'hF6);
      run_op("t3_zero", 8'hB4, 8'd0, 1'b0, 0, 8'hB4);
      run_op("t4_asr9", 8'h80, 8'd9, 1'b1, 8, 8'hFF);
      run_op("t4_lsr9", 8'h80, 8'd9, 1'b0, 8, 8'h00);
      run_op("t4_asr255", 8'h91, 8'hFF, 1'b1, 8, 8'hFF);
      run_op("t4_lsr7", 8'hFF, 8'd7, 1'b0, 7, 8'h01);

      // Request during SHIFT must be ignored.
      bus_i = 8'hF0; shift_i = 8'd4; arith_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      bus_i = 8'h0F; shift_i = 8'd1; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t5_c3_done", W'(done_o), W'(1'b0));
      step();
      check("t5_c4_done", W'(done_o), W'(1'b0));
      step();
      check("t5_c5_done", W'(done_o), W'(1'b1));
      check("t5_c5_result", bus_o, 8'h0F);
      step();
      check("t5_c6_busy", W'(busy_o), W'(1'b0));
      run_op("t5_b2b", 8'h0F, 8'd1, 1'b0, 1, 8'h07);

      // Reset in the middle of SHIFT aborts without a done strobe.
      bus_i = 8'hFF; shift_i = 8'd6; arith_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step(); step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("t6_rst_bus", bus_o, 8'h00);
      check("t6_rst_busy", W'(busy_o), W'(1'b0));
      check("t6_rst_done", W'(done_o), W'(1'b0));
      for (int i = 0; i < 10; i++) begin
         step();
         check("t6_no_done", W'(done_o), W'(1'b0));
      end

      // Reset and start together: the start is dropped.
      bus_i = 8'hAA; shift_i = 8'd2; start_i = 1'b1; rst_i = 1'b1;
      step();
      start_i = 1'b0; rst_i = 1'b0;
      check("t7_rst_start_busy", W'(busy_o), W'(1'b0));
      check("t7_rst_start_bus", bus_o, 8'h00);
      step();
      check("t7_rst_start_done", W'(done_o), W'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
